// File: rtl/morse_msg_arbiter_if.sv
// Requester/encoder-core bundle for the morse message arbiter.
// master = arbiter side, slave = requesters plus encoder core.
interface morse_msg_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           core_full;
  logic           core_empty;
  logic           write_en;
  logic [7:0]     ascii_in;
  logic [N-1:0]   grant;
  logic           busy;
  logic [1:0]     state_dbg;

  modport master (
    input  req_valid, req_data, req_last, core_full, core_empty,
    output req_ready, write_en, ascii_in, grant, busy, state_dbg
  );

  modport slave (
    output req_valid, req_data, req_last, core_full, core_empty,
    input  req_ready, write_en, ascii_in, grant, busy, state_dbg
  );
endinterface

// File: rtl/morse_msg_arbiter.sv
// Round-robin, message-granular arbiter feeding one morse encoder push port.
// Handshake: a requester beat transfers in the cycle req_valid[i] & req_ready[i] is high.
module morse_msg_arbiter #(
  parameter int         N          = 4,
  parameter int         INSERT_SEP = 1,
  parameter logic [7:0] SEP_CHAR   = 8'h20,
  parameter int         WAIT_EMPTY = 0
) (
  input logic                aclk,
  input logic                aresetn,
  morse_msg_arbiter_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    SEP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  next_idx;
  logic [IW-1:0]  cand;
  logic           found;
  logic [N-1:0]   grant;
  logic [N-1:0]   ready;
  logic           write_en;
  logic [7:0]     ascii;
  logic [7:0]     cur_data;
  logic           push_ok;
  logic           accept;
  logic           last_beat;

  // One push per two cycles so core_full always reflects the previous push.
  assign push_ok   = ~bus.core_full & ~write_en;
  assign ready     = (state == XFER && push_ok) ? (grant & bus.req_valid) : '0;
  assign accept    = |ready;
  assign last_beat = |(ready & bus.req_last);

  always_comb begin
    found    = 1'b0;
    next_idx = ptr;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && bus.req_valid[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) cur_data = bus.req_data[8*i +: 8];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      ptr      <= IW'(N - 1);
      grant    <= '0;
      write_en <= 1'b0;
      ascii    <= 8'h00;
    end else begin
      write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant <= N'(1) << next_idx;
            ptr   <= next_idx;
            state <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            write_en <= 1'b1;
            ascii    <= cur_data;
            if (last_beat) begin
              if (INSERT_SEP != 0) begin
                state <= SEP;
              end else if (WAIT_EMPTY != 0) begin
                state <= DRAIN;
              end else begin
                state <= IDLE;
                grant <= '0;
              end
            end
          end
        end
        SEP: begin
          if (push_ok) begin
            write_en <= 1'b1;
            ascii    <= SEP_CHAR;
            if (WAIT_EMPTY != 0) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end
        end
        DRAIN: begin
          if (~write_en & bus.core_empty) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.write_en  = write_en;
  assign bus.ascii_in  = ascii;
  assign bus.grant     = grant;
  assign bus.busy      = (state != IDLE);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_morse_msg_arbiter.sv
// Directed bench for morse_msg_arbiter: dut0 has no drain wait, dut1 waits for core empty.
module tb_morse_msg_arbiter;
  logic aclk;
  logic aresetn;

  morse_msg_arbiter_if #(.N(4)) bus0 ();
  morse_msg_arbiter_if #(.N(4)) bus1 ();

  morse_msg_arbiter #(.N(4), .INSERT_SEP(1), .SEP_CHAR(8'h20), .WAIT_EMPTY(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus0));
  morse_msg_arbiter #(.N(4), .INSERT_SEP(1), .SEP_CHAR(8'h20), .WAIT_EMPTY(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  // Clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Per-requester message streams for dut0
  logic [7:0] msg_buf [4][32];
  logic       msg_lst [4][32];
  int         msg_len [4];
  int         msg_pos [4];
  logic       hold    [4];

  logic [7:0] got_q[$];
  logic [7:0] got1_q[$];
  logic [7:0] exp_q[$];
  int         acc_q[$];
  int         gap_err = 0;
  int         cyc     = 0;
  int         last_we = -10;

  // Driver: present the current beat of each stream shortly after the falling edge.
  initial begin
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    forever begin
      @(negedge aclk);
      #2;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < 4; i++) begin
        if (msg_pos[i] < msg_len[i] && !hold[i]) begin
          v[i]       = 1'b1;
          l[i]       = msg_lst[i][msg_pos[i]];
          d[8*i +: 8] = msg_buf[i][msg_pos[i]];
        end
      end
      bus0.req_valid = v;
      bus0.req_last  = l;
      bus0.req_data  = d;
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      for (int i = 0; i < 4; i++) begin
        if (bus0.req_valid[i] && bus0.req_ready[i]) begin
          msg_pos[i]++;
          acc_q.push_back(i);
        end
      end
    end
  end

  // Monitor: capture push strobes on the falling edge
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (bus0.write_en === 1'b1) begin
        got_q.push_back(bus0.ascii_in);
        if (cyc - last_we < 2) gap_err++;
        last_we = cyc;
      end
      if (bus1.write_en === 1'b1) got1_q.push_back(bus1.ascii_in);
    end
  end

  task automatic load_msg(input int id, input string s);
    msg_len[id] = 0;
    msg_pos[id] = 0;
    for (int k = 0; k < s.len(); k++) begin
      if (s[k] == 8'h2E) begin
        msg_lst[id][msg_len[id]-1] = 1'b1;
      end else begin
        msg_buf[id][msg_len[id]] = s[k];
        msg_lst[id][msg_len[id]] = 1'b0;
        msg_len[id]++;
      end
    end
  endtask

  task automatic set_exp(input string s);
    exp_q.delete();
    for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
  endtask

  task automatic clear_streams();
    for (int i = 0; i < 4; i++) begin
      msg_len[i] = 0;
      msg_pos[i] = 0;
      hold[i]    = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    clear_streams();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    bit all_sent;
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge aclk);
      #3;
      all_sent = 1'b1;
      for (int i = 0; i < 4; i++) if (msg_pos[i] < msg_len[i]) all_sent = 1'b0;
      if (all_sent && bus0.busy === 1'b0 && bus0.write_en === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_first_push(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      #1;
      if (got_q.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (bus0.write_en !== 1'b0) begin n_fail++; $display("FAIL rst_write_en got=%b exp=0", bus0.write_en); end
    n_checks++;
    if (bus0.ascii_in !== 8'h00) begin n_fail++; $display("FAIL rst_ascii got=%h exp=00", bus0.ascii_in); end
    n_checks++;
    if (bus0.grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant got=%b exp=0000", bus0.grant); end
    n_checks++;
    if (bus0.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready got=%b exp=0000", bus0.req_ready); end
    n_checks++;
    if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b%b exp=00", bus0.busy, bus1.busy); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_sos();
    bit ok;
    apply_reset();
    got_q.delete();
    gap_err = 0;
    load_msg(0, "SOS.");
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sos_done got=timeout exp=idle"); end
    set_exp("SOS ");
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sos_len got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL sos_char%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
    end
    n_checks++;
    if (gap_err != 0) begin n_fail++; $display("FAIL sos_gap got=%0d exp=0", gap_err); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_ids[6] = '{0, 0, 1, 2, 2, 0};
    apply_reset();
    got_q.delete();
    acc_q.delete();
    gap_err = 0;
    load_msg(0, "AB.F.");
    load_msg(1, "C.");
    load_msg(2, "DE.");
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_done got=timeout exp=idle"); end
    set_exp("AB C DE F ");
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rr_len got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rr_char%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
    end
    n_checks++;
    if (acc_q.size() != 6) begin
      n_fail++; $display("FAIL rr_beats got=%0d exp=6", acc_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (acc_q[k] != exp_ids[k]) begin n_fail++; $display("FAIL rr_owner%0d got=%0d exp=%0d", k, acc_q[k], exp_ids[k]); end
      end
    end
    n_checks++;
    if (gap_err != 0) begin n_fail++; $display("FAIL rr_gap got=%0d exp=0", gap_err); end
  endtask

  task automatic test_full_stall();
    bit ok;
    got_q.delete();
    load_msg(0, "XYZ.");
    wait_first_push(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_start got=timeout exp=push"); end
    bus0.core_full = 1'b1;
    @(posedge aclk);
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      #1;
      n_checks++;
      if (bus0.req_ready !== 4'b0000 || bus0.write_en !== 1'b0) begin
        n_fail++; $display("FAIL full_hold%0d got=ready %b we %b exp=ready 0000 we 0", c, bus0.req_ready, bus0.write_en);
      end
    end
    bus0.core_full = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_done got=timeout exp=idle"); end
    set_exp("XYZ ");
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL full_len got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL full_char%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_stall_valid();
    bit ok;
    got_q.delete();
    load_msg(0, "PQ.");
    wait_first_push(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_start got=timeout exp=push"); end
    hold[0] = 1'b1;
    load_msg(3, "R.");
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      #3;
      n_checks++;
      if (bus0.grant !== 4'b0001) begin n_fail++; $display("FAIL stall_grant%0d got=%b exp=0001", c, bus0.grant); end
      n_checks++;
      if (bus0.req_ready[3] !== 1'b0) begin n_fail++; $display("FAIL stall_ready3_%0d got=%b exp=0", c, bus0.req_ready[3]); end
    end
    hold[0] = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_done got=timeout exp=idle"); end
    set_exp("PQ R ");
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_len got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL stall_char%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    got_q.delete();
    load_msg(0, "ABC.");
    wait_first_push(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rmid_start got=timeout exp=push"); end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (bus0.write_en !== 1'b0 || bus0.grant !== 4'b0000 || bus0.busy !== 1'b0 ||
        bus0.ascii_in !== 8'h00 || bus0.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmid_outputs got=we %b grant %b busy %b ascii %h ready %b exp=0 0000 0 00 0000",
               bus0.write_en, bus0.grant, bus0.busy, bus0.ascii_in, bus0.req_ready);
    end
    got_q.delete();
    load_msg(0, "G.");
    load_msg(3, "H.");
    repeat (2) @(negedge aclk);
    #4;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    n_checks++;
    if (bus0.grant !== 4'b0001) begin n_fail++; $display("FAIL rmid_regrant got=%b exp=0001", bus0.grant); end
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rmid_done got=timeout exp=idle"); end
    set_exp("G H ");
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rmid_len got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rmid_char%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_wait_empty();
    bit ok;
    got1_q.delete();
    bus1.core_empty = 1'b0;
    @(negedge aclk);
    #1;
    bus1.req_valid = 4'b0001;
    bus1.req_last  = 4'b0001;
    bus1.req_data  = 32'h0000_004B;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge aclk);
      if (bus1.req_ready[0] === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL we_accept got=timeout exp=ready"); end
    #1;
    bus1.req_valid = 4'b0000;
    bus1.req_last  = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      n_checks++;
      if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL we_busy%0d got=%b exp=1", c, bus1.busy); end
    end
    #1;
    set_exp("K ");
    n_checks++;
    if (got1_q.size() != 2) begin
      n_fail++; $display("FAIL we_len got=%0d exp=2", got1_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (got1_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL we_char%0d got=%h exp=%h", k, got1_q[k], exp_q[k]); end
      end
    end
    bus1.core_empty = 1'b1;
    bus1.req_valid  = 4'b0010;
    bus1.req_last   = 4'b0010;
    bus1.req_data   = 32'h0000_4C00;
    @(negedge aclk);
    #1;
    n_checks++;
    if (bus1.busy !== 1'b0 || bus1.grant !== 4'b0000) begin
      n_fail++; $display("FAIL we_idle got=busy %b grant %b exp=busy 0 grant 0000", bus1.busy, bus1.grant);
    end
    @(negedge aclk);
    #1;
    n_checks++;
    if (bus1.grant !== 4'b0010) begin n_fail++; $display("FAIL we_next_grant got=%b exp=0010", bus1.grant); end
    for (int c = 0; c < 20; c++) begin
      @(posedge aclk);
      if (bus1.req_ready[1] === 1'b1) break;
    end
    #1;
    bus1.req_valid = 4'b0000;
    bus1.req_last  = 4'b0000;
  endtask

  initial begin
    aresetn         = 1'b0;
    clear_streams();
    bus0.core_full  = 1'b0;
    bus0.core_empty = 1'b1;
    bus1.req_valid  = '0;
    bus1.req_last   = '0;
    bus1.req_data   = '0;
    bus1.core_full  = 1'b0;
    bus1.core_empty = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    test_reset();
    test_sos();
    test_round_robin();
    test_full_stall();
    test_stall_valid();
    test_reset_mid();
    test_wait_empty();
    repeat (3) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
